// File: rtl/tcp_tx_msg_poller_pkg.sv
// tcp_tx_msg_poller_pkg: TX tile sizes, destination struct and poller FSM states
package tcp_tx_msg_poller_pkg;
    localparam int MAX_FLOW_CNT = 8;
    localparam int FLOWID_W = $clog2(MAX_FLOW_CNT);
    localparam int TX_PAYLOAD_PTR_W = 12;
    localparam int XY_WIDTH = 8;
    localparam int NOC_FBITS_WIDTH = 4;
    typedef logic [FLOWID_W-1:0] flowid_t;
    typedef logic [TX_PAYLOAD_PTR_W:0] ptr_t;
    typedef logic [TX_PAYLOAD_PTR_W-1:0] len_t;
    typedef struct packed {
        logic [XY_WIDTH-1:0] x;
        logic [XY_WIDTH-1:0] y;
        logic [NOC_FBITS_WIDTH-1:0] fbits;
    } poller_dst_struct;
    typedef enum logic [1:0] {PICK, RD_REQ, RD_RESP, OUT} poller_state_e;
    // pointers carry a wrap bit, so the subtraction at full width yields occupancy directly
    function automatic ptr_t free_space(ptr_t head, ptr_t tail);
        return (ptr_t'(1) << TX_PAYLOAD_PTR_W) - (tail - head);
    endfunction
endpackage

// File: rtl/tcp_tx_msg_poller_if.sv
// tcp_tx_msg_poller_if: app arm, pointer-read and NoC metadata handshakes of the poller
interface tcp_tx_msg_poller_if;
    import tcp_tx_msg_poller_pkg::*;
    logic app_poller_req_val;
    flowid_t app_poller_req_flowid;
    logic [XY_WIDTH-1:0] app_poller_req_dst_x;
    logic [XY_WIDTH-1:0] app_poller_req_dst_y;
    logic [NOC_FBITS_WIDTH-1:0] app_poller_req_dst_fbits;
    logic poller_app_req_rdy;
    logic poller_ptr_rd_req_val;
    flowid_t poller_ptr_rd_req_flowid;
    logic ptr_poller_rd_req_rdy;
    logic ptr_poller_rd_resp_val;
    ptr_t ptr_poller_rd_resp_head;
    ptr_t ptr_poller_rd_resp_tail;
    logic poller_ptr_rd_resp_rdy;
    logic poller_msg_noc_if_meta_val;
    flowid_t poller_msg_noc_if_flowid;
    ptr_t poller_msg_noc_if_base_ptr;
    len_t poller_msg_noc_if_len;
    logic [XY_WIDTH-1:0] poller_msg_noc_if_dst_x;
    logic [XY_WIDTH-1:0] poller_msg_noc_if_dst_y;
    logic [NOC_FBITS_WIDTH-1:0] poller_msg_noc_if_dst_fbits;
    logic noc_if_poller_msg_meta_rdy;
    modport master (
        input app_poller_req_val, app_poller_req_flowid, app_poller_req_dst_x,
              app_poller_req_dst_y, app_poller_req_dst_fbits,
              ptr_poller_rd_req_rdy, ptr_poller_rd_resp_val, ptr_poller_rd_resp_head,
              ptr_poller_rd_resp_tail, noc_if_poller_msg_meta_rdy,
        output poller_app_req_rdy, poller_ptr_rd_req_val, poller_ptr_rd_req_flowid,
               poller_ptr_rd_resp_rdy, poller_msg_noc_if_meta_val, poller_msg_noc_if_flowid,
               poller_msg_noc_if_base_ptr, poller_msg_noc_if_len, poller_msg_noc_if_dst_x,
               poller_msg_noc_if_dst_y, poller_msg_noc_if_dst_fbits
    );
    modport slave (
        output app_poller_req_val, app_poller_req_flowid, app_poller_req_dst_x,
               app_poller_req_dst_y, app_poller_req_dst_fbits,
               ptr_poller_rd_req_rdy, ptr_poller_rd_resp_val, ptr_poller_rd_resp_head,
               ptr_poller_rd_resp_tail, noc_if_poller_msg_meta_rdy,
        input poller_app_req_rdy, poller_ptr_rd_req_val, poller_ptr_rd_req_flowid,
              poller_ptr_rd_resp_rdy, poller_msg_noc_if_meta_val, poller_msg_noc_if_flowid,
              poller_msg_noc_if_base_ptr, poller_msg_noc_if_len, poller_msg_noc_if_dst_x,
              poller_msg_noc_if_dst_y, poller_msg_noc_if_dst_fbits
    );
endinterface

// File: rtl/tcp_tx_msg_poller_rr_pick.sv
// tcp_tx_msg_poller_rr_pick: first armed flow strictly after rr_last, rr_last itself last
module tcp_tx_msg_poller_rr_pick
    import tcp_tx_msg_poller_pkg::*;
(
    input  logic [MAX_FLOW_CNT-1:0] armed,
    input  flowid_t rr_last,
    output logic found,
    output flowid_t flowid
);
    flowid_t idx;
    always_comb begin
        found = 1'b0;
        flowid = '0;
        idx = '0;
        for (int i = 1; i <= MAX_FLOW_CNT; i++) begin
            idx = flowid_t'((int'(rr_last) + i) % MAX_FLOW_CNT);
            if (!found && armed[idx]) begin
                found = 1'b1;
                flowid = idx;
            end
        end
    end
endmodule

// File: rtl/tcp_tx_msg_poller.sv
// tcp_tx_msg_poller: round-robin scan of armed flows, notifies NoC when TX space frees up
module tcp_tx_msg_poller
    import tcp_tx_msg_poller_pkg::*;
#(
    parameter int MIN_FREE = 1
) (
    input logic clk,
    input logic rst,
    tcp_tx_msg_poller_if.master bus
);
    logic [MAX_FLOW_CNT-1:0] armed;
    flowid_t rr_last, flow, pick_id;
    logic pick_found, arm;
    poller_state_e state;
    poller_dst_struct dst_mem [MAX_FLOW_CNT];
    poller_dst_struct dst_out;
    ptr_t free_len;
    assign arm = bus.app_poller_req_val & bus.poller_app_req_rdy;
    assign free_len = free_space(bus.ptr_poller_rd_resp_head, bus.ptr_poller_rd_resp_tail);
    assign bus.poller_msg_noc_if_dst_x = dst_out.x;
    assign bus.poller_msg_noc_if_dst_y = dst_out.y;
    assign bus.poller_msg_noc_if_dst_fbits = dst_out.fbits;
    tcp_tx_msg_poller_rr_pick u_pick (
        .armed(armed),
        .rr_last(rr_last),
        .found(pick_found),
        .flowid(pick_id)
    );
    always_ff @(posedge clk) begin
        if (arm)
            dst_mem[bus.app_poller_req_flowid] <= '{bus.app_poller_req_dst_x,
                bus.app_poller_req_dst_y, bus.app_poller_req_dst_fbits};
    end
    // the trailing arm set overrides the OUT-handshake clear when both hit the same flow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PICK;
            armed <= '0;
            rr_last <= flowid_t'(MAX_FLOW_CNT - 1);
            flow <= '0;
            dst_out <= '0;
            bus.poller_app_req_rdy <= 1'b0;
            bus.poller_ptr_rd_req_val <= 1'b0;
            bus.poller_ptr_rd_req_flowid <= '0;
            bus.poller_ptr_rd_resp_rdy <= 1'b0;
            bus.poller_msg_noc_if_meta_val <= 1'b0;
            bus.poller_msg_noc_if_flowid <= '0;
            bus.poller_msg_noc_if_base_ptr <= '0;
            bus.poller_msg_noc_if_len <= '0;
        end else begin
            bus.poller_app_req_rdy <= 1'b1;
            case (state)
                PICK: if (pick_found) begin
                    flow <= pick_id;
                    bus.poller_ptr_rd_req_flowid <= pick_id;
                    bus.poller_ptr_rd_req_val <= 1'b1;
                    state <= RD_REQ;
                end
                RD_REQ: if (bus.ptr_poller_rd_req_rdy) begin
                    bus.poller_ptr_rd_req_val <= 1'b0;
                    bus.poller_ptr_rd_resp_rdy <= 1'b1;
                    state <= RD_RESP;
                end
                RD_RESP: if (bus.ptr_poller_rd_resp_val) begin
                    bus.poller_ptr_rd_resp_rdy <= 1'b0;
                    if (free_len >= ptr_t'(MIN_FREE)) begin
                        bus.poller_msg_noc_if_meta_val <= 1'b1;
                        bus.poller_msg_noc_if_flowid <= flow;
                        bus.poller_msg_noc_if_base_ptr <= bus.ptr_poller_rd_resp_tail;
                        bus.poller_msg_noc_if_len <= free_len[TX_PAYLOAD_PTR_W] ? '1
                            : free_len[TX_PAYLOAD_PTR_W-1:0];
                        dst_out <= dst_mem[flow];
                        state <= OUT;
                    end else begin
                        rr_last <= flow;
                        state <= PICK;
                    end
                end
                OUT: if (bus.noc_if_poller_msg_meta_rdy) begin
                    bus.poller_msg_noc_if_meta_val <= 1'b0;
                    armed[flow] <= 1'b0;
                    rr_last <= flow;
                    state <= PICK;
                end
                default: state <= PICK;
            endcase
            if (arm)
                armed[bus.app_poller_req_flowid] <= 1'b1;
        end
    end
endmodule
